// File: rtl/jstk_spi_if.sv
// Bus between jstk_spi_ctrl and its neighbours: request/response handshake plus the SPI pins.
// The master modport is the controller's view; slave is the view of whoever drives START and MISO.
interface jstk_spi_if #(
    parameter int NUM_BYTES = 5
);
    logic                   START;
    logic [8*NUM_BYTES-1:0] TX_DATA;
    logic                   MISO;
    logic                   SS;
    logic                   SCLK;
    logic                   MOSI;
    logic                   BUSY;
    logic                   DONE;
    logic [8*NUM_BYTES-1:0] RX_DATA;

    modport master (
        input  START, TX_DATA, MISO,
        output SS, SCLK, MOSI, BUSY, DONE, RX_DATA
    );

    modport slave (
        output START, TX_DATA, MISO,
        input  SS, SCLK, MOSI, BUSY, DONE, RX_DATA
    );
endinterface

// File: rtl/jstk_spi_ctrl.sv
// SPI mode-0 master for one PmodJSTK2 transaction of NUM_BYTES bytes, MSB first.
// SCLK_IN is only sampled in the CLK domain; its edges pace every bit, gap and hold period.
module jstk_spi_ctrl #(
    parameter int NUM_BYTES     = 5,
    parameter int SETUP_PERIODS = 2,
    parameter int GAP_PERIODS   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCLK_IN,
    jstk_spi_if.master bus
);
    localparam int W       = 8 * NUM_BYTES;
    localparam int PER_MAX = (SETUP_PERIODS > GAP_PERIODS) ? SETUP_PERIODS : GAP_PERIODS;
    localparam int PER_W   = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, GAP, HOLD} state_t;

    state_t           state, state_nxt;
    logic             s1, s2;
    logic             rise_evt, fall_evt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic [3:0]       byte_cnt, byte_cnt_nxt;
    logic [PER_W-1:0] per_cnt, per_cnt_nxt;
    logic [W-1:0]     tx_sh, tx_sh_nxt;
    logic [W-1:0]     rx_sh, rx_sh_nxt;
    logic [W-1:0]     rx_data_nxt;
    logic             ss_nxt, mosi_nxt, busy_nxt, done_nxt;

    // Stage boundary: two-flop sampling of the divided clock
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= SCLK_IN;
            s2 <= s1;
        end
    end

    assign rise_evt = s1 & ~s2;
    assign fall_evt = ~s1 & s2;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ss_nxt       = bus.SS;
        mosi_nxt     = bus.MOSI;
        busy_nxt     = bus.BUSY;
        done_nxt     = 1'b0;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        per_cnt_nxt  = per_cnt;
        tx_sh_nxt    = tx_sh;
        rx_sh_nxt    = rx_sh;
        rx_data_nxt  = bus.RX_DATA;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    tx_sh_nxt    = bus.TX_DATA;
                    ss_nxt       = 1'b0;
                    busy_nxt     = 1'b1;
                    bit_cnt_nxt  = '0;
                    byte_cnt_nxt = '0;
                    per_cnt_nxt  = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                if (fall_evt) begin
                    if (per_cnt == PER_W'(SETUP_PERIODS - 1)) begin
                        mosi_nxt    = tx_sh[W-1];
                        bit_cnt_nxt = '0;
                        per_cnt_nxt = '0;
                        state_nxt   = XFER;
                    end else begin
                        per_cnt_nxt = per_cnt + 1'b1;
                    end
                end
            end
            XFER: begin
                if (rise_evt) begin
                    rx_sh_nxt   = {rx_sh[W-2:0], bus.MISO};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
                if (fall_evt) begin
                    if (bit_cnt < 4'd8) begin
                        tx_sh_nxt = tx_sh << 1;
                        mosi_nxt  = tx_sh[W-2];
                    end else begin
                        byte_cnt_nxt = byte_cnt + 1'b1;
                        if (int'(byte_cnt) + 1 < NUM_BYTES) begin
                            mosi_nxt    = 1'b0;
                            per_cnt_nxt = '0;
                            state_nxt   = GAP;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end
            end
            GAP: begin
                if (fall_evt) begin
                    if (per_cnt == PER_W'(GAP_PERIODS - 1)) begin
                        // tx_sh still holds the last bit of the previous byte in its MSB
                        tx_sh_nxt   = tx_sh << 1;
                        mosi_nxt    = tx_sh[W-2];
                        bit_cnt_nxt = '0;
                        per_cnt_nxt = '0;
                        state_nxt   = XFER;
                    end else begin
                        per_cnt_nxt = per_cnt + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (fall_evt) begin
                    ss_nxt      = 1'b1;
                    mosi_nxt    = 1'b0;
                    rx_data_nxt = rx_sh;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage boundary: registered control and pin outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.SS      <= 1'b1;
            bus.SCLK    <= 1'b0;
            bus.MOSI    <= 1'b0;
            bus.BUSY    <= 1'b0;
            bus.DONE    <= 1'b0;
            bus.RX_DATA <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            per_cnt     <= '0;
        end else begin
            bus.SS      <= ss_nxt;
            bus.SCLK    <= s1 & (state == XFER);
            bus.MOSI    <= mosi_nxt;
            bus.BUSY    <= busy_nxt;
            bus.DONE    <= done_nxt;
            bus.RX_DATA <= rx_data_nxt;
            bit_cnt     <= bit_cnt_nxt;
            byte_cnt    <= byte_cnt_nxt;
            per_cnt     <= per_cnt_nxt;
        end
    end

    // Shift registers are fully overwritten by every transaction, so they carry no reset
    always_ff @(posedge CLK) begin
        tx_sh <= tx_sh_nxt;
        rx_sh <= rx_sh_nxt;
    end
endmodule
